// File: rtl/lfsr_checker.sv
// Receive-side checker for the LFSR data/address generator: regenerates the expected stream and flags mismatches.
// Optional build macro LFSR_CHK_RESYNC_EN adds reseeding after RESYNC_THRESH consecutive bad words.
module lfsr_checker #(
  parameter int ERR_W         = 16,
  parameter int RESYNC_THRESH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             stop_on_err,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic [9:0]       in_addr,
  output logic [1:0]       mismatch,
  output logic             err_sticky,
  output logic [ERR_W-1:0] err_cnt,
  output logic [31:0]      word_cnt,
  output logic [31:0]      first_err_idx,
  output logic [1:0]       state
`ifdef LFSR_CHK_RESYNC_EN
  ,
  output logic [7:0]       resync_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_FAIL  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] exp_d;
  logic [9:0]  exp_a;
  logic        d_mis, a_mis, any_mis, xfer, reseed;

  function automatic logic [31:0] d_step(input logic [31:0] s);
    return {s[30:0], s[31]} ^ ({32{s[31]}} & 32'h0040_0006);
  endfunction

  function automatic logic [9:0] a_step(input logic [9:0] s);
    return {s[8:0], s[9]} ^ ({10{s[9]}} & 10'h008);
  endfunction

  // A word moves when in_valid && in_ready; in_ready is a pure function of state,
  // never of in_valid, and in_data/in_addr must be stable while in_valid is high.
  assign in_ready = (state_q == ST_CHECK);
  assign xfer     = in_valid && in_ready;
  assign d_mis    = (in_data != exp_d);
  assign a_mis    = (in_addr != exp_a);
  assign any_mis  = d_mis || a_mis;
  assign state    = state_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // start overrides everything, including a simultaneous stop.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ST_CHECK;
    end else begin
      case (state_q)
        ST_CHECK: begin
          if (stop)                                  state_d = ST_IDLE;
          else if (xfer && any_mis && stop_on_err)   state_d = ST_FAIL;
        end
        ST_FAIL:  if (stop) state_d = ST_IDLE;
        default:  state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      exp_d         <= 32'hFFFF_FFFF;
      exp_a         <= 10'h3FF;
      mismatch      <= 2'b00;
      err_sticky    <= 1'b0;
      err_cnt       <= '0;
      word_cnt      <= 32'd0;
      first_err_idx <= 32'd0;
    end else begin
      mismatch <= 2'b00;
      if (xfer) begin
        mismatch <= {a_mis, d_mis};
        word_cnt <= word_cnt + 32'd1;
        exp_d    <= reseed ? d_step(in_data) : d_step(exp_d);
        exp_a    <= reseed ? a_step(in_addr) : a_step(exp_a);
        if (any_mis) begin
          err_sticky <= 1'b1;
          if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
          if (!err_sticky)   first_err_idx <= word_cnt;
        end
      end
    end
  end

`ifdef LFSR_CHK_RESYNC_EN
  localparam int CW = $clog2(RESYNC_THRESH + 1);
  localparam logic [CW-1:0] THRESH = CW'(RESYNC_THRESH);

  logic [CW-1:0] consec_q, consec_next;
  logic [7:0]    resync_q;

  // The run counter parks at the threshold so an all-zero (lock-up) word just retries next time.
  always_comb begin
    consec_next = (consec_q == THRESH) ? consec_q : consec_q + 1'b1;
    reseed      = xfer && any_mis && !stop_on_err && (consec_next == THRESH)
                  && (in_data != 32'd0) && (in_addr != 10'd0);
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      consec_q <= '0;
      resync_q <= 8'd0;
    end else if (xfer && !stop_on_err) begin
      if (!any_mis) begin
        consec_q <= '0;
      end else if (reseed) begin
        consec_q <= '0;
        if (resync_q != 8'hFF) resync_q <= resync_q + 8'd1;
      end else begin
        consec_q <= consec_next;
      end
    end
  end

  assign resync_cnt = resync_q;
`else
  assign reseed = 1'b0;
`endif

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Receive-side checker for the pseudo-random traffic produced by the team's LFSR data/address generator. It regenerates the expected 32-bit data and 10-bit address sequences locally, compares every accepted word against them, and reports mismatches, counts and the index of the first failure. It sits at the sink end of the BRAM/AXI test path, opposite the generator.

## Interface
- ERR_W, 16, width of saturating error counter
- RESYNC_THRESH, 4, consecutive mismatched words that trigger a reseed (only with LFSR_CHK_RESYNC_EN)
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse: load seeds, clear counters, enter CHECK
- stop  in  1  pulse: return to IDLE, counters held
- stop_on_err  in  1  1 = enter FAIL on first mismatch
- in_valid  in  1  word offered
- in_ready  out  1  checker accepts word
- in_data  in  32  received data word
- in_addr  in  10  received address
- mismatch  out  2  {addr_mis, data_mis}, one-cycle registered pulse
- err_sticky  out  1  set on any mismatch, cleared by start/rst
- err_cnt  out  ERR_W  mismatched words, saturates at all-ones
- word_cnt  out  32  accepted words, wraps
- first_err_idx  out  32  word_cnt value of first mismatching word
- state  out  2  IDLE=0, CHECK=1, FAIL=2
- resync_cnt  out  8  reseed events (present only with LFSR_CHK_RESYNC_EN)

## Operation
- Decided: one clock; reset is synchronous and active-high. Ports named clk and rst.
- Transfer = in_valid && in_ready. in_ready = 1 in CHECK, 0 in IDLE/FAIL. in_ready must not depend combinationally on in_valid.
- Expected data exp_d, seed 0xFFFFFFFF; Galois step: n[0]=s[31], n[1]=s[0]^s[31], n[2]=s[1]^s[31], n[22]=s[21]^s[31], else n[i]=s[i-1].
- Expected addr exp_a, seed 0x3FF; step: n[0]=s[9], n[3]=s[2]^s[9], else n[i]=s[i-1].
- Generator emits seed first, then stepped values; word k must equal step^k(seed). step(0xFFFFFFFF)=0xFFBFFFF9, step(0x3FF)=0x3F7.
- Each transfer: compare in_data vs exp_d and in_addr vs exp_a; step exp_d/exp_a; word_cnt++.
- On mismatch: mismatch bits set, err_cnt++ (saturating), err_sticky=1; first_err_idx=word_cnt (pre-increment) only if err_sticky was 0.
- FSM: IDLE -start-> CHECK. CHECK -mismatch & stop_on_err-> FAIL. CHECK/FAIL -stop-> IDLE. start in any state restarts CHECK (reseed, clear counters). start and stop same cycle: start wins. rst or start mid-stream discards in-flight comparison.

## Timing
- Reset values: state=IDLE, in_ready=0, mismatch=0, err_sticky=0, err_cnt=0, word_cnt=0, first_err_idx=0, resync_cnt=0, exp_d=0xFFFFFFFF, exp_a=0x3FF.
- Comparison registered at transfer edge: mismatch, counters, first_err_idx visible the cycle after transfer; latency 1.
- FAIL entered at the edge of the bad transfer; in_ready low from the next cycle; the bad word counts as accepted.
- start: CHECK and in_ready=1 the cycle after the pulse; counters read 0 that cycle.
- word_cnt 0xFFFFFFFF + 1 -> 0, no flag. err_cnt holds at 2^ERR_W-1.

## Configuration
- LFSR_CHK_RESYNC_EN defined: in CHECK with stop_on_err=0, a consecutive-mismatch counter counts bad words (cleared on any good word). On the RESYNC_THRESH-th consecutive bad word, exp_d/exp_a load step(in_data)/step(in_addr) instead of stepping, counter clears, resync_cnt++ (saturating at 255). No reseed if in_data==0 or in_addr==0 (lock-up state); the counter then holds at threshold and retries on the next bad word. Mismatches still counted normally.
- Undefined: no reseed logic, no resync_cnt port; expected sequence only steps.

## Test plan
- Reset, start, send 1000 generator words with in_valid=1 -> mismatch never set, err_cnt=0, word_cnt=1000; word1 = 0xFFBFFFF9/0x3F7.
- stop_on_err=1, word 5 data bit 0 flipped -> mismatch=2'b01 one cycle after, state=FAIL, in_ready=0, first_err_idx=5, word_cnt=6.
- stop_on_err=0, words 3 and 7 addr corrupted -> err_cnt=2, first_err_idx=3, other words clean, stays CHECK.
- Random in_valid gaps plus start and stop in same cycle mid-stream -> no lost/duplicated steps; start wins, counters zero, sequence restarts at seed.
- ERR_W=4, 20 bad words -> err_cnt saturates at 15; word_cnt=20.
- LFSR_CHK_RESYNC_EN, stream started at generator word 50 -> 4 mismatches, resync_cnt=1, then clean; an all-zero word at threshold -> no reseed.
